// File: rtl/ps2_frame_fifo.sv
// PS/2 receive front end: synchronises the pins into clk, deserialises frames,
// checks odd parity and stop bit, and queues results in a first-word fall-through FIFO.
module ps2_frame_fifo #(
  parameter int DATA_BITS      = 8,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     rd_ready,
  input  logic                     ovf_clr,
  output logic                     rd_valid,
  output logic [DATA_BITS-1:0]     rd_data,
  output logic                     rd_parity_err,
  output logic                     rd_frame_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     timeout
);

  localparam int FRAME_W = DATA_BITS + 2;
  localparam int ENTRY_W = DATA_BITS + 2;
  localparam int CNT_W   = $clog2(DATA_BITS + 3);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  function automatic logic odd_parity_err(input logic [DATA_BITS:0] bits);
    return ~(^bits);
  endfunction

  function automatic logic stop_err(input logic stop_bit);
    return ~stop_bit;
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev_p0;
  logic                   fall_p0;
  logic                   bit_p0;

  logic [1:0]             state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [FRAME_W-1:0]     sreg;
  logic [WD_W-1:0]        wd;

  logic [ENTRY_W-1:0]     entry_p1;
  logic [ENTRY_W-1:0]     mem [DEPTH];
  logic [ENTRY_W-1:0]     head;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   accept;
  logic                   drop;

  // Stage p0: pin synchronisers, idle-high so reset never looks like a clock fall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync    <= '1;
      dat_sync    <= '1;
      clk_prev_p0 <= 1'b1;
    end else begin
      clk_sync    <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync    <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev_p0 <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall_p0 = clk_prev_p0 & ~clk_sync[SYNC_STAGES-1];
  assign bit_p0  = dat_sync[SYNC_STAGES-1];

  // Frame deserialiser; bits enter at the MSB so the first data bit lands at sreg[0]
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sreg    <= '0;
      wd      <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (fall_p0 && !bit_p0) begin
            state   <= SHIFT;
            bit_cnt <= CNT_W'(1);
            wd      <= '0;
          end
        end
        SHIFT: begin
          if (fall_p0) begin
            sreg <= {bit_p0, sreg[FRAME_W-1:1]};
            wd   <= '0;
            if (bit_cnt == CNT_W'(DATA_BITS + 2)) state <= CHECK;
            else bit_cnt <= bit_cnt + 1'b1;
          end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
            state   <= IDLE;
            bit_cnt <= '0;
            wd      <= '0;
            timeout <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        CHECK: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: CHECK cycle builds the flagged entry and offers it to the FIFO
  assign entry_p1 = {stop_err(sreg[DATA_BITS+1]),
                     odd_parity_err(sreg[DATA_BITS:0]),
                     sreg[DATA_BITS-1:0]};

  assign push   = (state == CHECK);
  assign pop    = rd_valid & rd_ready;
  assign full   = (count == (PTR_W + 1)'(DEPTH));
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= entry_p1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop wins over a simultaneous clear so no loss goes unreported
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign rd_valid      = (count != '0);
  assign head          = mem[rd_ptr];
  assign rd_data       = rd_valid ? head[DATA_BITS-1:0] : '0;
  assign rd_parity_err = rd_valid & head[DATA_BITS];
  assign rd_frame_err  = rd_valid & head[DATA_BITS+1];

endmodule

// File: tb/tb_ps2_frame_fifo.sv
// Scoreboard bench for ps2_frame_fifo: frames are bit-banged on the pins, expected
// entries queued at the stop bit, and a monitor checks every accepted FIFO read.
module tb_ps2_frame_fifo;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int TO    = 100;
  localparam int SS    = 2;
  localparam int H     = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ps2_clk = 1'b1;
  logic          ps2_data = 1'b1;
  logic          rd_ready;
  logic          ovf_clr = 1'b0;
  logic          rd_valid;
  logic [DB-1:0] rd_data;
  logic          rd_parity_err;
  logic          rd_frame_err;
  logic [$clog2(DEPTH):0] count;
  logic          overflow;
  logic          timeout;

  logic rdy_manual = 1'b0;
  logic rand_rdy = 1'b0;
  logic rnd_bit = 1'b0;
  assign rd_ready = rand_rdy ? rnd_bit : rdy_manual;

  int n_cmp = 0;
  int n_bad = 0;
  int to_cnt = 0;
  logic exp_ovf = 1'b0;
  logic [DB+1:0] exp_q[$];

  ps2_frame_fifo #(.DATA_BITS(DB), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_ready(rd_ready), .ovf_clr(ovf_clr), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_parity_err(rd_parity_err), .rd_frame_err(rd_frame_err), .count(count),
    .overflow(overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference rule: a finished frame is queued unless the FIFO is full with no read that cycle
  task automatic model_push(input logic [DB-1:0] d, input logic perr, input logic ferr,
                            input logic pop_same);
    if (exp_q.size() >= DEPTH && !pop_same) exp_ovf = 1'b1;
    else exp_q.push_back({ferr, perr, d});
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk); ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // mode: 0 plain, 1 latency check, 2 read pulse on CHECK cycle, 3 ovf_clr pulse on CHECK cycle
  task automatic send_frame(input logic [DB-1:0] d, input logic par_flip, input logic stop,
                            input int mode);
    logic par;
    logic [DB+2:0] bits;
    par  = ~(^d) ^ par_flip;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < DB + 2; i++) drive_bit(bits[i]);
    @(negedge clk); ps2_data = stop;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    model_push(d, ((^d) ^ par) == 1'b0, stop == 1'b0, mode == 2);
    if (mode == 1) begin
      repeat (SS + 2) @(negedge clk);
      #1;
      check("latency_valid", rd_valid, 1);
      check("latency_count", count, exp_q.size());
    end else if (mode >= 2) begin
      repeat (SS + 1) @(negedge clk);
      if (mode == 2) rdy_manual = 1'b1;
      else ovf_clr = 1'b1;
      @(negedge clk);
      rdy_manual = 1'b0;
      ovf_clr = 1'b0;
    end
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
    @(negedge clk); ps2_data = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic drain();
    rdy_manual = 1'b1;
    for (int i = 0; i < 300 && (exp_q.size() != 0 || rd_valid); i++) @(negedge clk);
    rdy_manual = 1'b0;
    @(negedge clk); #1;
    check("drain_count", count, 0);
    check("drain_queue_left", exp_q.size(), 0);
  endtask

  task automatic pulse_clr();
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    #1;
    check("ovf_after_clr", overflow, exp_ovf);
  endtask

  initial forever begin
    @(negedge clk); rnd_bit = 1'($urandom_range(0, 1));
  end

  // Monitor: samples just before each rising edge
  initial begin
    logic [DB+1:0] e;
    forever begin
      @(negedge clk); #4;
      if (reset_n && timeout) to_cnt++;
      if (reset_n && rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_pop: got 0x%0h, expected no entry",
                   {rd_frame_err, rd_parity_err, rd_data});
        end else begin
          e = exp_q.pop_front();
          check("pop_entry", {rd_frame_err, rd_parity_err, rd_data}, e);
        end
      end
    end
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", rd_valid, 0);
    check("rst_count", count, 0);
    check("rst_data", rd_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout", timeout, 0);
    @(negedge clk); reset_n = 1'b1;
    repeat (4) @(negedge clk);

    send_frame(8'h1C, 1'b0, 1'b1, 1);
    drain();

    send_frame(8'h1C, 1'b1, 1'b1, 0);
    send_frame(8'h1C, 1'b0, 1'b0, 0);
    send_frame(8'hA7, 1'b1, 1'b0, 0);
    #1; check("err_frames_count", count, 3);
    drain();

    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 0);
    #1;
    check("full_count", count, DEPTH);
    check("full_overflow", overflow, exp_ovf);
    drain();
    check("ovf_sticky", overflow, exp_ovf);
    pulse_clr();

    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b1, 0);
    send_frame(8'h15, 1'b0, 1'b1, 2);
    #1;
    check("pushpop_count", count, DEPTH);
    check("pushpop_overflow", overflow, exp_ovf);
    send_frame(8'h16, 1'b0, 1'b1, 3);
    #1;
    check("drop_vs_clr_overflow", overflow, exp_ovf);
    check("drop_vs_clr_count", count, DEPTH);
    drain();
    pulse_clr();

    base = to_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1);
    for (int i = 0; i < TO + 40 && to_cnt == base; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    #1;
    check("timeout_pulses", to_cnt - base, 1);
    check("timeout_count", count, 0);
    send_frame(8'hF0, 1'b0, 1'b1, 0);
    drain();

    send_frame(8'h33, 1'b0, 1'b1, 0);
    for (int i = 0; i < 5; i++) drive_bit(1'(i == 0 ? 0 : i % 2));
    @(negedge clk); #2;
    reset_n = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    check("midrst_valid", rd_valid, 0);
    check("midrst_count", count, 0);
    check("midrst_data", rd_data, 0);
    check("midrst_errs", {rd_frame_err, rd_parity_err}, 0);
    check("midrst_overflow", overflow, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b1, 1);
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 16; i++)
      send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) != 0, 0);
    rand_rdy = 1'b0;
    drain();
    check("random_overflow", overflow, exp_ovf);
    check("total_timeouts", to_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
